// File: rtl/gcm_pkg.sv
// Shared types for the GCM result scroller: big-endian block/word types and window selection.
package gcm_pkg;

   typedef logic [0:127] block_t;
   typedef logic [0:15]  disp_word_t;

   localparam int unsigned NUM_WINDOWS = 16;

   typedef logic [0:$clog2(NUM_WINDOWS)-1] window_t;

   typedef enum logic {
      WAIT   = 1'b0,
      SCROLL = 1'b1
   } scroll_state_t;

   // Window MSB picks tag over cipher text; low bits pick the 16-bit word, MSB-first.
   function automatic disp_word_t window_word(input block_t ct, input block_t tag,
                                              input window_t w);
      logic [6:0] base;
      base = {w[1:3], 4'b0000};
      return w[0] ? tag[base +: 16] : ct[base +: 16];
   endfunction

endpackage

// File: rtl/step_timer.sv
// Auto-scroll interval counter: counts while enabled, ticks on its last count.
module step_timer #(
   parameter int unsigned STEP_CYCLES = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CntW = $clog2(STEP_CYCLES);
   localparam logic [CntW-1:0] LastCnt = CntW'(STEP_CYCLES - 1);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i || !enable_i) begin
         count_d = '0;
      end else if (count_q == LastCnt) begin
         count_d = '0;
      end else begin
         count_d = count_q + CntW'(1);
      end
   end

   assign tick_o = enable_i && (count_q == LastCnt);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/gcm_result_scroller.sv
// Holds the first cipher text/tag of a GCM instance and scrolls it as 16-bit display windows.
module gcm_result_scroller
   import gcm_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       i_reset_n,
   input  logic       i_new_instance,
   input  block_t     i_cipher_text,
   input  block_t     i_tag,
   input  logic       i_tag_ready,
   input  logic       i_step,
   input  logic       i_auto,
   output disp_word_t o_x,
   output logic       o_valid,
   output window_t    o_window,
   output logic       o_sel
);

   scroll_state_t state_q, state_d;
   window_t       window_q, window_d;
   disp_word_t    x_q, x_d;
   logic          valid_q, valid_d;
   block_t        ct_q, ct_d;
   block_t        tag_q, tag_d;
   logic          advance;
   logic          tick;
   logic          timer_clear;

   assign timer_clear = advance || i_new_instance || (state_q != SCROLL);

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk_i   (clk),
      .rst_ni  (i_reset_n),
      .enable_i(i_auto),
      .clear_i (timer_clear),
      .tick_o  (tick)
   );

   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      x_d      = x_q;
      valid_d  = valid_q;
      ct_d     = ct_q;
      tag_d    = tag_q;
      advance  = 1'b0;
      // A new instance blanks the display but keeps the old capture in place.
      if (i_new_instance) begin
         state_d  = WAIT;
         window_d = '0;
         x_d      = '0;
         valid_d  = 1'b0;
      end else begin
         unique case (state_q)
            WAIT: begin
               if (i_tag_ready) begin
                  ct_d     = i_cipher_text;
                  tag_d    = i_tag;
                  window_d = '0;
                  x_d      = window_word(i_cipher_text, i_tag, '0);
                  valid_d  = 1'b1;
                  state_d  = SCROLL;
               end
            end
            SCROLL: begin
               advance = i_step || tick;
               if (advance) begin
                  window_d = window_q + 4'd1;
                  x_d      = window_word(ct_q, tag_q, window_d);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state_q  <= WAIT;
         window_q <= '0;
         x_q      <= '0;
         valid_q  <= 1'b0;
         ct_q     <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         x_q      <= x_d;
         valid_q  <= valid_d;
         ct_q     <= ct_d;
         tag_q    <= tag_d;
      end
   end

   assign o_x      = x_q;
   assign o_valid  = valid_q;
   assign o_window = window_q;
   assign o_sel    = window_q[0];

endmodule

// File: tb/tb_gcm_result_scroller.sv
// Directed bench for gcm_result_scroller with STEP_CYCLES=4.
module tb_gcm_result_scroller;
   import gcm_pkg::*;

   logic       clk = 1'b0;
   logic       i_reset_n;
   logic       i_new_instance;
   block_t     i_cipher_text;
   block_t     i_tag;
   logic       i_tag_ready;
   logic       i_step;
   logic       i_auto;
   disp_word_t o_x;
   logic       o_valid;
   window_t    o_window;
   logic       o_sel;

   int nvec = 0;
   int nerr = 0;

   localparam block_t Ct1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam block_t Tag1 = {8{16'hA5A5}};
   localparam block_t Ct2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam block_t Tag2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

   gcm_result_scroller #(
      .STEP_CYCLES(4)
   ) dut (
      .clk           (clk),
      .i_reset_n     (i_reset_n),
      .i_new_instance(i_new_instance),
      .i_cipher_text (i_cipher_text),
      .i_tag         (i_tag),
      .i_tag_ready   (i_tag_ready),
      .i_step        (i_step),
      .i_auto        (i_auto),
      .o_x           (o_x),
      .o_valid       (o_valid),
      .o_window      (o_window),
      .o_sel         (o_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       step;
      logic [3:0] win;
      logic [15:0] x;
      logic       sel;
   } vec_t;

   vec_t steps[16];

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [3:0] w,
                          input logic [15:0] x, input logic s);
      chk({name, ".valid"}, 32'(o_valid), 32'(v));
      chk({name, ".window"}, 32'(o_window), 32'(w));
      chk({name, ".x"}, 32'(o_x), 32'(x));
      chk({name, ".sel"}, 32'(o_sel), 32'(s));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] ct1_words[16];
      ct1_words = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD,
                    16'hEEFF, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5,
                    16'hA5A5, 16'hA5A5};
      for (int i = 0; i < 16; i++) begin
         steps[i].step = 1'b1;
         steps[i].win  = 4'((i + 1) % 16);
         steps[i].x    = ct1_words[(i + 1) % 16];
         steps[i].sel  = ((i + 1) % 16) >= 8;
      end

      i_reset_n = 1'b0; i_new_instance = 1'b0; i_cipher_text = '0; i_tag = '0;
      i_tag_ready = 1'b0; i_step = 1'b0; i_auto = 1'b0;
      cyc(2);
      chk_out("reset", 1'b0, 4'd0, 16'h0000, 1'b0);

      // Capture; step in WAIT before it must be ignored.
      i_reset_n = 1'b1; i_cipher_text = Ct1; i_tag = Tag1; i_step = 1'b1;
      cyc(1);
      i_step = 1'b0;
      chk_out("wait_step", 1'b0, 4'd0, 16'h0000, 1'b0);
      i_tag_ready = 1'b1;
      cyc(1);
      i_tag_ready = 1'b0;
      chk_out("capture", 1'b1, 4'd0, 16'h0011, 1'b0);

      for (int i = 0; i < 16; i++) begin
         i_step = steps[i].step;
         cyc(1);
         i_step = 1'b0;
         chk_out($sformatf("step%0d", i + 1), 1'b1, steps[i].win, steps[i].x, steps[i].sel);
      end

      // Auto scroll every 4 cycles.
      i_auto = 1'b1;
      cyc(3);
      chk("auto_hold0", 32'(o_window), 32'd0);
      cyc(1);
      chk_out("auto_adv1", 1'b1, 4'd1, 16'h2233, 1'b0);
      cyc(3);
      chk("auto_hold1", 32'(o_window), 32'd1);
      cyc(1);
      chk("auto_adv2", 32'(o_window), 32'd2);
      cyc(3);
      i_step = 1'b1;
      cyc(1);
      i_step = 1'b0;
      chk_out("step_on_expiry", 1'b1, 4'd3, 16'h6677, 1'b0);
      cyc(3);
      chk("post_expiry_hold", 32'(o_window), 32'd3);
      cyc(1);
      chk("post_expiry_adv", 32'(o_window), 32'd4);

      // Second tag_ready in SCROLL is ignored.
      i_auto = 1'b0; i_cipher_text = Ct2; i_tag = Tag2; i_tag_ready = 1'b1;
      cyc(1);
      i_tag_ready = 1'b0;
      chk_out("sticky", 1'b1, 4'd4, 16'h8899, 1'b0);
      i_step = 1'b1;
      cyc(1);
      i_step = 1'b0;
      chk("sticky_next", 32'(o_x), 32'h0000AABB);

      // New instance beats same-cycle tag_ready and step.
      i_new_instance = 1'b1; i_tag_ready = 1'b1; i_step = 1'b1;
      cyc(1);
      i_new_instance = 1'b0; i_tag_ready = 1'b0; i_step = 1'b0;
      chk_out("new_inst", 1'b0, 4'd0, 16'h0000, 1'b0);
      cyc(1);
      chk_out("new_inst_idle", 1'b0, 4'd0, 16'h0000, 1'b0);
      i_tag_ready = 1'b1;
      cyc(1);
      i_tag_ready = 1'b0;
      chk_out("recapture", 1'b1, 4'd0, 16'h0123, 1'b0);
      for (int i = 0; i < 9; i++) begin
         i_step = 1'b1;
         cyc(1);
      end
      i_step = 1'b0;
      chk_out("tag_word1", 1'b1, 4'd9, 16'h2222, 1'b1);
      i_step = 1'b1;
      cyc(6);
      i_step = 1'b0;
      chk_out("tag_word7", 1'b1, 4'd15, 16'h8888, 1'b1);
      i_step = 1'b1;
      cyc(6);
      i_step = 1'b0;
      chk_out("win5", 1'b1, 4'd5, 16'hBA98, 1'b0);

      // Reset mid-scroll with auto running.
      i_auto = 1'b1; i_reset_n = 1'b0;
      cyc(1);
      i_reset_n = 1'b1;
      chk_out("reset_mid", 1'b0, 4'd0, 16'h0000, 1'b0);
      i_tag_ready = 1'b1;
      cyc(1);
      i_tag_ready = 1'b0;
      chk_out("reset_recap", 1'b1, 4'd0, 16'h0123, 1'b0);
      cyc(3);
      chk("timer_restart_hold", 32'(o_window), 32'd0);
      cyc(1);
      chk_out("timer_restart_adv", 1'b1, 4'd1, 16'h4567, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
